// File: rtl/uart_rx_8n1.sv
// UART receiver: 2-flop synchronised rx, start-edge aligned mid-bit sampling, 8N1 deframing.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit (drives perr).
module uart_rx_8n1 #(
  parameter int BAUD_DIV = 104
) (
  input  logic       sys_clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       perr,
  output logic       busy
);
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LD_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] LD_FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          rx_m, rx_s, rx_prev;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tick, fall;
  logic          ld_half, ld_full, shift_en, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_en, par_q, perr_q;
`endif

  assign tick = (baud_q == '0);
  assign fall = rx_prev & ~rx_s;
  assign busy = (state_q != IDLE);

  // History resets high so a line held low through reset still reads as a start edge.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          ld_half = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = DATA;
            ld_full = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          ld_full  = 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_en  = 1'b1;
          ld_full = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data    <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_half)      baud_q <= LD_HALF;
      else if (ld_full) baud_q <= LD_FULL;
      else              baud_q <= baud_q - CW'(1);
      if (ld_half)       bit_q <= '0;
      else if (shift_en) bit_q <= bit_q + 3'd1;
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
      if (stop_ok)  data    <= shift_q;
      valid <= stop_ok;
      ferr  <= stop_bad;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (par_en) par_q <= rx_s;
      perr_q <= stop_ok & (^shift_q ^ par_q);
    end
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at BAUD_DIV=16: scoreboard of expected strobes,
// a vector table of frames, and hand sequences for timing, glitch, framing error and reset.
module tb_uart_rx_8n1;
  localparam int B    = 16;
  localparam int HALF = B / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       sys_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, perr, busy;

  uart_rx_8n1 #(.BAUD_DIV(B)) dut (
    .sys_clk(sys_clk),
    .rstn   (rstn),
    .rx     (rx),
    .data   (data),
    .valid  (valid),
    .ferr   (ferr),
    .perr   (perr),
    .busy   (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       flip;
    int         hold_low;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   drop_cyc = 0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic v, input logic f, input logic p);
    exp_t e;
    e = '{data: d, valid: v, ferr: f, perr: p};
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (B) @(negedge sys_clk);
  endtask

  // flip=1 inverts the even-parity bit when parity is enabled.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    drop_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ flip);
`endif
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  // Scoreboard side: every strobe must match the oldest expectation.
  always @(negedge sys_clk) begin
    if (rstn && (valid || ferr || perr)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got data=%0h valid=%0b ferr=%0b perr=%0b, expected no strobe (cycle %0d)",
                 data, valid, ferr, perr, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe{data,valid,ferr,perr}", {20'd0, data, valid, ferr, perr}, {20'd0, e});
        if (valid) check("busy_at_valid", {31'd0, busy}, 32'd0);
      end
      if (valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       v;
    logic [7:0] d7;

    // Table: frame in, expected strobe out.
    v = '{8'h00, 1'b1, 1'b0, 0,  8'h00, 1'b0, 1'b0}; vecs.push_back(v);
    v = '{8'hFF, 1'b1, 1'b0, 0,  8'hFF, 1'b0, 1'b0}; vecs.push_back(v);
    v = '{8'h80, 1'b1, 1'b0, 0,  8'h80, 1'b0, 1'b0}; vecs.push_back(v);
    v = '{8'hC3, 1'b0, 1'b0, 20, 8'h80, 1'b1, 1'b0}; vecs.push_back(v);
    v = '{8'h01, 1'b1, 1'b0, 0,  8'h01, 1'b0, 1'b0}; vecs.push_back(v);
`ifdef UART_RX_PARITY_EN
    v = '{8'h01, 1'b1, 1'b1, 0,  8'h01, 1'b0, 1'b1}; vecs.push_back(v);
    v = '{8'h01, 1'b1, 1'b0, 0,  8'h01, 1'b0, 1'b0}; vecs.push_back(v);
    v = '{8'h5A, 1'b1, 1'b1, 0,  8'h5A, 1'b0, 1'b1}; vecs.push_back(v);
`endif

    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_data",  {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr",  {31'd0, ferr}, 32'd0);
    check("reset_perr",  {31'd0, perr}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    idle(4);

    // Exact latency of the valid strobe.
    push_exp(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(4);
    check("t1_valid_cycle", last_valid_cyc, drop_cyc + 2 + HALF + (FRAME_BITS - 1) * B + 1);

    // Back-to-back frames, one stop bit each.
    push_exp(8'h48, 1'b1, 1'b0, 1'b0);
    push_exp(8'h65, 1'b1, 1'b0, 1'b0);
    send_frame(8'h48, 1'b1, 1'b0);
    send_frame(8'h65, 1'b1, 1'b0);
    idle(4);
    check("t2_valid_spacing", last_valid_cyc - prev_valid_cyc, FRAME_BITS * B);

    // Start glitch: low for 5 cycles only.
    idle(2 * B);
    rx = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge sys_clk);
      if (i == 5) rx = 1'b1;
      if (i == 3) check("t3_busy_after_edge", {31'd0, busy}, 32'd1);
      if (i == 10) check("t3_busy_at_sample", {31'd0, busy}, 32'd1);
      if (i == 11) check("t3_busy_after_glitch", {31'd0, busy}, 32'd0);
    end
    idle(B);
    push_exp(8'h2A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h2A, 1'b1, 1'b0);

    // Framing error, line held low, then recovery.
    idle(B);
    push_exp(8'h2A, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (50) @(negedge sys_clk);
    check("t4_busy_line_low", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("t4_busy_sync_delay", {31'd0, busy}, 32'd1);
    @(negedge sys_clk);
    check("t4_busy_released", {31'd0, busy}, 32'd0);
    idle(B);
    push_exp(8'h21, 1'b1, 1'b0, 1'b0);
    send_frame(8'h21, 1'b1, 1'b0);

    foreach (vecs[k]) begin
      idle(B);
      push_exp(vecs[k].exp_data, ~vecs[k].exp_ferr, vecs[k].exp_ferr, vecs[k].exp_perr);
      send_frame(vecs[k].d, vecs[k].stop, vecs[k].flip);
      if (!vecs[k].stop) begin
        repeat (vecs[k].hold_low) @(negedge sys_clk);
        idle(4);
      end
    end

    // Reset after data bit 3 of 0x7E; the partial frame must vanish.
    idle(2 * B);
    d7 = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d7[i]);
    rstn = 1'b0;
    rx   = 1'b1;
    @(negedge sys_clk);
    rstn = 1'b1;
    check("t5_reset_data",  {24'd0, data}, 32'h00);
    check("t5_reset_valid", {31'd0, valid}, 32'd0);
    check("t5_reset_ferr",  {31'd0, ferr}, 32'd0);
    check("t5_reset_busy",  {31'd0, busy}, 32'd0);
    idle(3 * B);
    check("t5_no_strobe_data", {24'd0, data}, 32'h00);
    push_exp(8'h7E, 1'b1, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);

    idle(4 * B);
    check("drain_expected_strobes", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
